regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file: NW write ports, NR read ports, registered reads.
//   Per-port conflict flags replace the single global collision flag of the 2R1W file.
//   Optional write-to-read bypass and a background clear engine that zeroes the array.
//   Used as the architectural register store in datapath blocks needing more than 2R1W.
// PARAMETERS
//   DATA_WIDTH  32  bits per entry
//   DEPTH       32  number of entries, 2..2**ADDR_WIDTH
//   ADDR_WIDTH  5   address bits per port
//   NR          2   read ports, 1..8
//   NW          1   write ports, 1..4
//   BYPASS      0   0: read/write address clash is a read collision; 1: forward write data
// PORTS
//   clk           in   1              clock, all state on posedge
//   reset         in   1              synchronous, active-high
//   din           in   NW*DATA_WIDTH  write data, port w at [w*DATA_WIDTH +: DATA_WIDTH]
//   wad           in   NW*ADDR_WIDTH  write addresses, packed like din
//   wen           in   NW             write enables
//   rad           in   NR*ADDR_WIDTH  read addresses
//   ren           in   NR             read enables
//   clr_req       in   1              single-cycle pulse, start array clear
//   dout          out  NR*DATA_WIDTH  registered read data
//   rd_collision  out  NR             read port r collided this cycle (registered)
//   wr_collision  out  NW             write port w was dropped (registered)
//   clr_busy      out  1              clear engine active
// BEHAVIOUR
//   - Reset: every entry 0; dout, rd_collision, wr_collision and clr_busy are 0; FSM in IDLE.
//   - Read latency is 1 cycle. If ren[r]=0, dout[r] <= 0 and rd_collision[r] <= 0.
//   - A read sees array contents from before this edge's writes (read-before-write).
//   - Two read ports on the same address are legal; both return the data and no flag is set.
//   - Read r hits an enabled write address, BYPASS=0: dout[r] <= 0, rd_collision[r] <= 1.
//     The write is still performed.
//   - Same case with BYPASS=1: dout[r] <= din of the winning writer; rd_collision[r] <= 0.
//   - Write/write on the same address: the lowest-index port wins.
//     Each losing port gets wr_collision[w] <= 1 and its write is dropped.
//   - Address >= DEPTH: the write is dropped and wr_collision[w] <= 1.
//     A read returns 0 and sets rd_collision[r] <= 1.
//   - Flags are per-cycle registered pulses and are not sticky.
//   - Clear FSM has states IDLE and CLEAR.
//     - IDLE: clr_req=1 -> CLEAR, ptr <= 0, clr_busy <= 1.
//     - CLEAR: entry[ptr] <= 0 and ptr increments each cycle.
//       Once ptr=DEPTH-1 is zeroed -> IDLE, and clr_busy falls on the next edge.
//     - A full clear takes exactly DEPTH cycles.
//     - clr_req while in CLEAR is ignored.
//     - In CLEAR, every enabled write is dropped with wr_collision[w] <= 1.
//       Reads proceed normally and may return not-yet-cleared data.
//   - reset mid-clear: returns to IDLE and zeroes the whole array in that cycle.
//   - ptr is $clog2(DEPTH) bits wide and does not wrap past DEPTH-1.
// STRUCTURE
//   - regfile_pkg holds the clear FSM state enum (CLR_IDLE, CLR_ACTIVE).
//     It also holds the port-slice helper functions get_rd_addr, get_wr_addr and get_wr_data.
//   - One sub-module, regfile_mp_conflict, is purely combinational.
//     It computes write winners, per-read hit/forward select, and out-of-range flags.
//   - The top level holds the array, output registers and clear FSM.
// TESTING
//   All scenarios use DATA_WIDTH=32, DEPTH=32, NR=2, NW=2.
//   1. reset=1 for 2 cycles, then read addresses 0 and 31.
//      -> dout=0 for both, all flags 0, clr_busy=0.
//   2. Write w0 addr3=0xA5A5_0003, next cycle ren[0],ren[1] both addr3.
//      -> both dout=0xA5A5_0003 one cycle later, no flags.
//   3. BYPASS=0: w0 writes addr7=0x77 and r1 reads addr7 in the same cycle.
//      -> dout[1]=0 and rd_collision[1]=1. The following read of addr7 returns 0x77.
//      BYPASS=1: the same stimulus gives dout[1]=0x77 and rd_collision[1]=0.
//   4. w0 writes addr5=0x11 and w1 writes addr5=0x22 in the same cycle.
//      -> wr_collision=2'b10, and a later read of addr5 returns 0x11.
//   5. Fill all 32 entries nonzero, then pulse clr_req.
//      -> clr_busy is high for 32 cycles and all reads then return 0.
//      A write issued at clear cycle 10 is dropped with wr_collision[0]=1.
//   6. Pulse clr_req, then assert reset at clear cycle 5.
//      -> next cycle clr_busy=0, array all zero, FSM in IDLE.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and port-slice helpers for the multi-port register file.
// Helpers operate on buses widened to the MAX_* limits; callers zero-extend and truncate.
package regfile_pkg;

  typedef enum logic {
    CLR_IDLE,
    CLR_ACTIVE
  } clr_state_e;

  localparam int MAX_DW = 64;
  localparam int MAX_AW = 16;
  localparam int MAX_NR = 8;
  localparam int MAX_NW = 4;

  function automatic logic [MAX_AW-1:0] get_rd_addr(input logic [MAX_NR*MAX_AW-1:0] bus,
                                                    input int unsigned idx,
                                                    input int unsigned aw);
    return MAX_AW'(bus >> (idx * aw));
  endfunction

  function automatic logic [MAX_AW-1:0] get_wr_addr(input logic [MAX_NW*MAX_AW-1:0] bus,
                                                    input int unsigned idx,
                                                    input int unsigned aw);
    return MAX_AW'(bus >> (idx * aw));
  endfunction

  function automatic logic [MAX_DW-1:0] get_wr_data(input logic [MAX_NW*MAX_DW-1:0] bus,
                                                    input int unsigned idx,
                                                    input int unsigned dw);
    return MAX_DW'(bus >> (idx * dw));
  endfunction

endpackage

// File: rtl/regfile_mp_conflict.sv
// Combinational port arbitration: write winners, read/write hits with forward select,
// and out-of-range detection. Lowest-index writer wins an address clash.
module regfile_mp_conflict
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int NR         = 2,
  parameter int NW         = 1,
  parameter int SEL_W      = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic [NW*ADDR_WIDTH-1:0] wad,
  input  logic [NW-1:0]            wen,
  input  logic [NR*ADDR_WIDTH-1:0] rad,
  input  logic [NR-1:0]            ren,
  input  logic                     clr_active,
  output logic [NW-1:0]            wr_ok,
  output logic [NW-1:0]            wr_drop,
  output logic [NR-1:0]            rd_oor,
  output logic [NR-1:0]            rd_hit,
  output logic [NR-1:0][SEL_W-1:0] rd_sel
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wa [NW];
  logic [ADDR_WIDTH-1:0] ra [NR];
  logic [NW-1:0]         w_inr;
  logic [NR-1:0]         r_inr;

  for (genvar g = 0; g < NW; g++) begin : g_wr
    assign wa[g]    = ADDR_WIDTH'(get_wr_addr((MAX_NW*MAX_AW)'(wad), g, ADDR_WIDTH));
    assign w_inr[g] = {1'b0, wa[g]} < DEPTH_L;
  end

  for (genvar g = 0; g < NR; g++) begin : g_rd
    assign ra[g]    = ADDR_WIDTH'(get_rd_addr((MAX_NR*MAX_AW)'(rad), g, ADDR_WIDTH));
    assign r_inr[g] = {1'b0, ra[g]} < DEPTH_L;
  end

  always_comb begin
    logic lost;
    lost    = 1'b0;
    wr_ok   = '0;
    wr_drop = '0;
    rd_oor  = '0;
    rd_hit  = '0;
    rd_sel  = '0;
    for (int w = 0; w < NW; w++) begin
      lost = 1'b0;
      for (int j = 0; j < w; j++) begin
        if (wen[j] && w_inr[j] && (wa[j] == wa[w])) lost = 1'b1;
      end
      wr_ok[w]   = wen[w] && w_inr[w] && !lost && !clr_active;
      wr_drop[w] = wen[w] && !wr_ok[w];
    end
    for (int r = 0; r < NR; r++) begin
      rd_oor[r] = ren[r] && !r_inr[r];
      // Descending scan so the lowest-index performed write is selected last.
      for (int w = NW - 1; w >= 0; w--) begin
        if (wr_ok[w] && (wa[w] == ra[r])) begin
          rd_hit[r] = 1'b1;
          rd_sel[r] = SEL_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, per-port conflict flags,
// optional write-to-read bypass and a background clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NR         = 2,
  parameter int NW         = 1,
  parameter int BYPASS     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NW*DATA_WIDTH-1:0] din,
  input  logic [NW*ADDR_WIDTH-1:0] wad,
  input  logic [NW-1:0]            wen,
  input  logic [NR*ADDR_WIDTH-1:0] rad,
  input  logic [NR-1:0]            ren,
  input  logic                     clr_req,
  output logic [NR*DATA_WIDTH-1:0] dout,
  output logic [NR-1:0]            rd_collision,
  output logic [NW-1:0]            wr_collision,
  output logic                     clr_busy
);

  localparam int PW    = $clog2(DEPTH);
  localparam int SEL_W = (NW > 1) ? $clog2(NW) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wd  [NW];
  logic [ADDR_WIDTH-1:0] wa  [NW];
  logic [ADDR_WIDTH-1:0] ra  [NR];

  clr_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [NW-1:0]            wr_ok, wr_drop;
  logic [NR-1:0]            rd_oor, rd_hit;
  logic [NR-1:0][SEL_W-1:0] rd_sel;

  for (genvar g = 0; g < NW; g++) begin : g_wr
    assign wd[g] = DATA_WIDTH'(get_wr_data((MAX_NW*MAX_DW)'(din), g, DATA_WIDTH));
    assign wa[g] = ADDR_WIDTH'(get_wr_addr((MAX_NW*MAX_AW)'(wad), g, ADDR_WIDTH));
  end

  for (genvar g = 0; g < NR; g++) begin : g_rd
    assign ra[g] = ADDR_WIDTH'(get_rd_addr((MAX_NR*MAX_AW)'(rad), g, ADDR_WIDTH));
  end

  regfile_mp_conflict #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .NR         (NR),
    .NW         (NW),
    .SEL_W      (SEL_W)
  ) u_conflict (
    .wad        (wad),
    .wen        (wen),
    .rad        (rad),
    .ren        (ren),
    .clr_active (state_q == CLR_ACTIVE),
    .wr_ok      (wr_ok),
    .wr_drop    (wr_drop),
    .rd_oor     (rd_oor),
    .rd_hit     (rd_hit),
    .rd_sel     (rd_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_ACTIVE;
          ptr_d   = '0;
        end
      end
      CLR_ACTIVE: begin
        if (ptr_q == PW'(DEPTH - 1)) state_d = CLR_IDLE;
        else                         ptr_d   = ptr_q + 1'b1;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign clr_busy = (state_q == CLR_ACTIVE);

  // Writes are blocked by the conflict unit while clearing, so the two never collide here.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state_q == CLR_ACTIVE) mem[ptr_q] <= '0;
      for (int w = 0; w < NW; w++) begin
        if (wr_ok[w]) mem[wa[w][PW-1:0]] <= wd[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout         <= '0;
      rd_collision <= '0;
      wr_collision <= '0;
    end else begin
      wr_collision <= wr_drop;
      for (int r = 0; r < NR; r++) begin
        if (!ren[r] || rd_oor[r]) begin
          dout[r*DATA_WIDTH +: DATA_WIDTH] <= '0;
          rd_collision[r]                  <= rd_oor[r];
        end else if (rd_hit[r]) begin
          if (BYPASS != 0) begin
            dout[r*DATA_WIDTH +: DATA_WIDTH] <= wd[rd_sel[r]];
            rd_collision[r]                  <= 1'b0;
          end else begin
            dout[r*DATA_WIDTH +: DATA_WIDTH] <= '0;
            rd_collision[r]                  <= 1'b1;
          end
        end else begin
          dout[r*DATA_WIDTH +: DATA_WIDTH] <= mem[ra[r][PW-1:0]];
          rd_collision[r]                  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a BYPASS=0 and a BYPASS=1 instance share all stimulus.
// Vector table plus hand sequences for clear, clear-ignore and reset-during-clear.
module tb_regfile_mp;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0;
    logic [31:0] d0;
    logic [4:0]  wa1;
    logic [31:0] d1;
    logic [1:0]  ren;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] x0;
    logic [31:0] x1;
    logic [1:0]  xrc;
    logic [1:0]  xwc;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [1:0]  brc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] din = '0;
  logic [9:0]  wad = '0;
  logic [1:0]  wen = '0;
  logic [9:0]  rad = '0;
  logic [1:0]  ren = '0;
  logic        clr_req = 1'b0;

  logic [63:0] dout, dout_b;
  logic [1:0]  rc, rc_b, wc, wc_b;
  logic        busy, busy_b;

  int   n_pass = 0;
  int   n_total = 0;
  vec_t sb[$];
  vec_t vecs[14];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .NR(2), .NW(2), .BYPASS(0)) dut (
    .clk(clk), .reset(reset), .din(din), .wad(wad), .wen(wen), .rad(rad), .ren(ren),
    .clr_req(clr_req), .dout(dout), .rd_collision(rc), .wr_collision(wc), .clr_busy(busy)
  );

  regfile_mp #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .NR(2), .NW(2), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .din(din), .wad(wad), .wen(wen), .rad(rad), .ren(ren),
    .clr_req(clr_req), .dout(dout_b), .rd_collision(rc_b), .wr_collision(wc_b), .clr_busy(busy_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] wen_i, input int wa0, input logic [31:0] d0,
                              input int wa1, input logic [31:0] d1, input logic [1:0] ren_i,
                              input int ra0, input int ra1, input logic [31:0] x0,
                              input logic [31:0] x1, input logic [1:0] xrc, input logic [1:0] xwc,
                              input logic [31:0] b0, input logic [31:0] b1, input logic [1:0] brc);
    vec_t v;
    v.wen = wen_i; v.wa0 = 5'(wa0); v.d0 = d0; v.wa1 = 5'(wa1); v.d1 = d1;
    v.ren = ren_i; v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
    v.x0 = x0; v.x1 = x1; v.xrc = xrc; v.xwc = xwc;
    v.b0 = b0; v.b1 = b1; v.brc = brc;
    return v;
  endfunction

  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    wen = v.wen; wad = {v.wa1, v.wa0}; din = {v.d1, v.d0};
    ren = v.ren; rad = {v.ra1, v.ra0}; clr_req = 1'b0;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_dout"},   dout,   {e.x1, e.x0});
    chk({tag, "_rc"},     rc,     e.xrc);
    chk({tag, "_wc"},     wc,     e.xwc);
    chk({tag, "_dout_b"}, dout_b, {e.b1, e.b0});
    chk({tag, "_rc_b"},   rc_b,   e.brc);
    chk({tag, "_wc_b"},   wc_b,   e.xwc);
  endtask

  task automatic run_clear(input string tag, input int drop_at, input int req_at, output int cnt);
    int c;
    cnt = 0;
    c   = 0;
    @(negedge clk);
    wen = 2'b00; ren = 2'b00; clr_req = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_busy_start"}, busy, 1'b1);
    while (busy && c < 40) begin
      @(negedge clk);
      clr_req = (c == req_at);
      wen     = (c == drop_at) ? 2'b01 : 2'b00;
      wad     = {5'd0, 5'd2};
      din     = {32'h0, 32'h0000_0055};
      @(posedge clk);
      #1;
      cnt++;
      if (c == drop_at) chk({tag, "_write_drop"}, wc, 2'b01);
      c++;
    end
    @(negedge clk);
    wen = 2'b00; clr_req = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'd32);
  endtask

  initial begin
    int cnt;
    vecs[0]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 0, 31, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    vecs[1]  = mk(2'b01, 3, 32'hA5A5_0003, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    vecs[2]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 3, 3, 32'hA5A5_0003, 32'hA5A5_0003, 2'b00, 2'b00,
                  32'hA5A5_0003, 32'hA5A5_0003, 2'b00);
    vecs[3]  = mk(2'b01, 7, 32'h77, 0, 0, 2'b10, 0, 7, 0, 0, 2'b10, 2'b00, 0, 32'h77, 2'b00);
    vecs[4]  = mk(2'b00, 0, 0, 0, 0, 2'b10, 0, 7, 0, 32'h77, 2'b00, 2'b00, 0, 32'h77, 2'b00);
    vecs[5]  = mk(2'b11, 5, 32'h11, 5, 32'h22, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 2'b00);
    vecs[6]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 5, 3, 32'h11, 32'hA5A5_0003, 2'b00, 2'b00,
                  32'h11, 32'hA5A5_0003, 2'b00);
    vecs[7]  = mk(2'b10, 0, 0, 9, 32'h99, 2'b01, 9, 0, 0, 0, 2'b01, 2'b00, 32'h99, 0, 2'b00);
    vecs[8]  = mk(2'b11, 10, 32'hA, 11, 32'hB, 2'b11, 10, 11, 0, 0, 2'b11, 2'b00,
                  32'hA, 32'hB, 2'b00);
    vecs[9]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 9, 10, 32'h99, 32'hA, 2'b00, 2'b00,
                  32'h99, 32'hA, 2'b00);
    vecs[10] = mk(2'b00, 0, 0, 0, 0, 2'b00, 9, 10, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    vecs[11] = mk(2'b00, 0, 0, 0, 0, 2'b11, 11, 11, 32'hB, 32'hB, 2'b00, 2'b00,
                  32'hB, 32'hB, 2'b00);
    vecs[12] = mk(2'b11, 12, 32'hC0, 12, 32'hC1, 2'b01, 12, 0, 0, 0, 2'b01, 2'b10,
                  32'hC0, 0, 2'b00);
    vecs[13] = mk(2'b00, 0, 0, 0, 0, 2'b01, 12, 0, 32'hC0, 0, 2'b00, 2'b00, 32'hC0, 0, 2'b00);

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 64'h0);
    chk("rst_rc", rc, 2'b00);
    chk("rst_wc", wc, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) apply($sformatf("v%0d", i), vecs[i]);

    // Fill every entry with a nonzero pattern
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wen = 2'b11;
      wad = {5'(i + 16), 5'(i)};
      din = {32'hC000_0000 + 32'(i + 16), 32'hC000_0000 + 32'(i)};
      ren = 2'b00;
      @(posedge clk);
    end
    apply("fill", mk(2'b00, 0, 0, 0, 0, 2'b11, 2, 31, 32'hC000_0002, 32'hC000_001F, 2'b00, 2'b00,
                     32'hC000_0002, 32'hC000_001F, 2'b00));

    // Full clear with a dropped write at cycle 10 and an ignored clr_req at cycle 3
    run_clear("clr", 10, 3, cnt);
    for (int i = 0; i < 16; i++)
      apply($sformatf("clr_rd%0d", i),
            mk(2'b00, 0, 0, 0, 0, 2'b11, i, i + 16, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00));

    // Reset at clear cycle 5 must zero entries the engine has not reached yet
    apply("pre_w", mk(2'b11, 20, 32'h2020, 30, 32'h3030, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00,
                      0, 0, 2'b00));
    apply("pre_r", mk(2'b00, 0, 0, 0, 0, 2'b11, 20, 30, 32'h2020, 32'h3030, 2'b00, 2'b00,
                      32'h2020, 32'h3030, 2'b00));
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_busy_start", busy, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clr_req = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_busy_b", busy_b, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply("mid_rd", mk(2'b00, 0, 0, 0, 0, 2'b11, 20, 30, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00));
    apply("mid_wr", mk(2'b01, 6, 32'h66, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00));
    run_clear("post_rst", 40, 40, cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
